cc_branch_ctrl: RTL and testbench

CC_BRANCH_CTRL -- requirements
Module: cc_branch_ctrl

---
 rtl/cc_branch_ctrl_if.sv | 26 ++
 rtl/cc_branch_ctrl.sv | 133 +++++++++++++
 tb/tb_cc_branch_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/cc_branch_ctrl_if.sv
// Branch-evaluation handshake between the decode stage and cc_branch_ctrl.
interface cc_branch_ctrl_if;
    logic       br_valid;
    logic [2:0] br_nzp;
    logic       br_ready;
    logic       br_done;
    logic       br_taken;

    // Requester side: issues the BR mask, receives the decision.
    modport master (
        output br_valid,
        output br_nzp,
        input  br_ready,
        input  br_done,
        input  br_taken
    );

    // Controller side.
    modport slave (
        input  br_valid,
        input  br_nzp,
        output br_ready,
        output br_done,
        output br_taken
    );
endinterface

// File: rtl/cc_branch_ctrl.sv
// Condition-code tracker and BR evaluator. It does a two-stage CC update from
// the register-write bus, does a direct PSR load, stalls branches on a CC
// hazard, and keeps a saturating count of taken branches.
module cc_branch_ctrl #(
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [15:0]          bus_in,
    input  logic                 ld_cc,
    input  logic                 psr_wr,
    input  logic [2:0]           psr_nzp,
    input  logic                 cnt_clr,
    cc_branch_ctrl_if.slave      br,
    output logic [2:0]           cc_nzp,
    output logic [CNT_W-1:0]     taken_cnt,
    output logic                 cc_err
);

    localparam int unsigned BUS_W    = 16;
    localparam logic [2:0]  CC_RESET = 3'b010;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE = 1'b0,
        EVAL = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [BUS_W-1:0]   bus_q, bus_d;
    logic               pending_q, pending_d;
    logic [2:0]         cc_q, cc_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               taken_q, taken_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_c;
    logic               hs_c;

    // A branch may only sample the CC when no update is queued or arriving.
    always_comb begin
        ready_c = (state_q == IDLE) && !pending_q && !ld_cc && !psr_wr;
        hs_c    = br.br_valid && ready_c;
    end

    // Next-state, CC pipeline, branch decision and counter.
    always_comb begin
        state_d   = state_q;
        bus_d     = bus_q;
        pending_d = 1'b0;
        cc_d      = cc_q;
        err_d     = err_q;
        done_d    = 1'b0;
        taken_d   = 1'b0;
        cnt_d     = cnt_q;

        // CC source: a PSR load beats a queued bus update and a new capture.
        if (psr_wr) begin
            if ($onehot(psr_nzp)) begin
                cc_d = psr_nzp;
            end else begin
                cc_d  = CC_RESET;
                err_d = 1'b1;
            end
        end else begin
            if (pending_q) begin
                cc_d = {bus_q[BUS_W-1],
                        (bus_q == '0),
                        !bus_q[BUS_W-1] && (bus_q != '0)};
            end
            if (ld_cc) begin
                bus_d     = bus_in;
                pending_d = 1'b1;
            end
        end

        // The CC cannot move between the handshake and EVAL, so the decision
        // is resolved at the handshake and simply presented during EVAL.
        unique case (state_q)
            IDLE: begin
                if (hs_c) begin
                    state_d = EVAL;
                    done_d  = 1'b1;
                    taken_d = |(br.br_nzp & cc_q);
                end
            end
            EVAL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (cnt_clr) begin
            cnt_d = '0;
        end else if (done_q && taken_q && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bus_q     <= '0;
            pending_q <= 1'b0;
            cc_q      <= CC_RESET;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            taken_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            bus_q     <= bus_d;
            pending_q <= pending_d;
            cc_q      <= cc_d;
            err_q     <= err_d;
            done_q    <= done_d;
            taken_q   <= taken_d;
            cnt_q     <= cnt_d;
        end
    end

    // Ready is forced low while reset is held.
    assign br.br_ready = rst_n && ready_c;
    assign br.br_done  = done_q;
    assign br.br_taken = taken_q;
    assign cc_nzp      = cc_q;
    assign taken_cnt   = cnt_q;
    assign cc_err      = err_q;

endmodule

// File: tb/tb_cc_branch_ctrl.sv
// Directed bench for cc_branch_ctrl, built with a 2-bit counter so that
// saturation is reachable.
module tb_cc_branch_ctrl;

    localparam int unsigned CNT_W = 2;

    logic             clk;
    logic             rst_n;
    logic [15:0]      bus_in;
    logic             ld_cc;
    logic             psr_wr;
    logic [2:0]       psr_nzp;
    logic             cnt_clr;
    logic [2:0]       cc_nzp;
    logic [CNT_W-1:0] taken_cnt;
    logic             cc_err;

    int passed;
    int total;

    cc_branch_ctrl_if br_if();

    cc_branch_ctrl #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_in    (bus_in),
        .ld_cc     (ld_cc),
        .psr_wr    (psr_wr),
        .psr_nzp   (psr_nzp),
        .cnt_clr   (cnt_clr),
        .br        (br_if.slave),
        .cc_nzp    (cc_nzp),
        .taken_cnt (taken_cnt),
        .cc_err    (cc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one branch from an idle, hazard-free state and check its result.
    task automatic do_branch(input logic [2:0] mask, input logic exp_taken);
        br_if.br_valid = 1'b1;
        br_if.br_nzp   = mask;
        #1;
        chk("br_ready_idle", 16'(br_if.br_ready), 16'd1);
        tick();
        br_if.br_valid = 1'b0;
        chk("br_done_eval", 16'(br_if.br_done), 16'd1);
        chk("br_taken_eval", 16'(br_if.br_taken), 16'(exp_taken));
        tick();
        chk("br_done_after", 16'(br_if.br_done), 16'd0);
        chk("br_taken_after", 16'(br_if.br_taken), 16'd0);
    endtask

    logic [15:0] vec_bus [5];
    logic [2:0]  vec_cc  [5];

    initial begin
        passed = 0;
        total  = 0;
        rst_n = 1'b1;
        bus_in = '0; ld_cc = 1'b0; psr_wr = 1'b0; psr_nzp = '0; cnt_clr = 1'b0;
        br_if.br_valid = 1'b0;
        br_if.br_nzp   = '0;

        // Reset values while reset is held.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_cc", 16'(cc_nzp), 16'b010);
        chk("rst_ready", 16'(br_if.br_ready), 16'd0);
        chk("rst_done", 16'(br_if.br_done), 16'd0);
        chk("rst_taken", 16'(br_if.br_taken), 16'd0);
        chk("rst_cnt", 16'(taken_cnt), 16'd0);
        chk("rst_err", 16'(cc_err), 16'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("ready_after_rst", 16'(br_if.br_ready), 16'd1);

        // Back-to-back CC loads, one cycle lag each.
        vec_bus[0] = 16'hFFFF; vec_cc[0] = 3'b100;
        vec_bus[1] = 16'h0000; vec_cc[1] = 3'b010;
        vec_bus[2] = 16'h0001; vec_cc[2] = 3'b001;
        vec_bus[3] = 16'hFFD6; vec_cc[3] = 3'b100;
        vec_bus[4] = 16'h00EA; vec_cc[4] = 3'b001;
        for (int i = 0; i < 5; i++) begin
            ld_cc  = 1'b1;
            bus_in = vec_bus[i];
            tick();
            if (i > 0) chk("cc_seq", 16'(cc_nzp), 16'(vec_cc[i-1]));
        end
        ld_cc = 1'b0;
        #1;
        chk("ready_pending", 16'(br_if.br_ready), 16'd0);
        tick();
        chk("cc_seq_last", 16'(cc_nzp), 16'(vec_cc[4]));

        // Branch decisions against cc=001.
        do_branch(3'b001, 1'b1);
        chk("cnt_1", 16'(taken_cnt), 16'd1);
        do_branch(3'b110, 1'b0);
        chk("cnt_still_1", 16'(taken_cnt), 16'd1);
        do_branch(3'b111, 1'b1);
        chk("cnt_2", 16'(taken_cnt), 16'd2);
        do_branch(3'b000, 1'b0);
        chk("cnt_still_2", 16'(taken_cnt), 16'd2);

        // CC hazard stall: ld_cc with 0 concurrent with a request.
        ld_cc = 1'b1; bus_in = 16'h0000;
        br_if.br_valid = 1'b1; br_if.br_nzp = 3'b010;
        #1;
        chk("stall_ready_0", 16'(br_if.br_ready), 16'd0);
        tick();
        ld_cc = 1'b0;
        #1;
        chk("stall_ready_1", 16'(br_if.br_ready), 16'd0);
        chk("stall_no_done", 16'(br_if.br_done), 16'd0);
        tick();
        chk("stall_cc", 16'(cc_nzp), 16'b010);
        chk("stall_ready_ok", 16'(br_if.br_ready), 16'd1);
        tick();
        br_if.br_valid = 1'b0;
        chk("stall_done", 16'(br_if.br_done), 16'd1);
        chk("stall_taken", 16'(br_if.br_taken), 16'd1);
        tick();
        chk("cnt_3", 16'(taken_cnt), 16'd3);

        // Saturation at 3 with a 2-bit counter.
        do_branch(3'b010, 1'b1);
        chk("cnt_sat_a", 16'(taken_cnt), 16'd3);
        do_branch(3'b111, 1'b1);
        chk("cnt_sat_b", 16'(taken_cnt), 16'd3);

        // Clear coinciding with a taken result: clear wins.
        br_if.br_valid = 1'b1; br_if.br_nzp = 3'b010;
        tick();
        br_if.br_valid = 1'b0;
        cnt_clr = 1'b1;
        chk("clr_taken", 16'(br_if.br_taken), 16'd1);
        tick();
        cnt_clr = 1'b0;
        chk("cnt_clr_wins", 16'(taken_cnt), 16'd0);
        do_branch(3'b010, 1'b1);
        chk("cnt_after_clr", 16'(taken_cnt), 16'd1);

        // psr_wr beats a same-cycle ld_cc.
        psr_wr = 1'b1; psr_nzp = 3'b100;
        ld_cc = 1'b1; bus_in = 16'h0001;
        tick();
        psr_wr = 1'b0; ld_cc = 1'b0;
        chk("psr_cc", 16'(cc_nzp), 16'b100);
        chk("psr_err_0", 16'(cc_err), 16'd0);
        tick();
        chk("psr_no_late_ld", 16'(cc_nzp), 16'b100);

        // Queued ld_cc discarded by psr_wr; non-one-hot value sets error.
        ld_cc = 1'b1; bus_in = 16'h0005;
        tick();
        ld_cc = 1'b0;
        psr_wr = 1'b1; psr_nzp = 3'b011;
        tick();
        psr_wr = 1'b0;
        chk("psr_bad_cc", 16'(cc_nzp), 16'b010);
        chk("psr_bad_err", 16'(cc_err), 16'd1);
        tick();
        chk("pending_dropped", 16'(cc_nzp), 16'b010);

        // cc_err is sticky across a later legal load.
        psr_wr = 1'b1; psr_nzp = 3'b001;
        tick();
        psr_wr = 1'b0;
        chk("psr_good_cc", 16'(cc_nzp), 16'b001);
        chk("err_sticky", 16'(cc_err), 16'd1);

        // A CC write during EVAL does not disturb the in-flight result.
        br_if.br_valid = 1'b1; br_if.br_nzp = 3'b001;
        tick();
        br_if.br_valid = 1'b0;
        psr_wr = 1'b1; psr_nzp = 3'b100;
        #1;
        chk("eval_taken_held", 16'(br_if.br_taken), 16'd1);
        chk("eval_cc_held", 16'(cc_nzp), 16'b001);
        tick();
        psr_wr = 1'b0;
        chk("eval_cc_after", 16'(cc_nzp), 16'b100);
        chk("eval_done_after", 16'(br_if.br_done), 16'd0);

        // Reset mid-EVAL aborts the request.
        br_if.br_valid = 1'b1; br_if.br_nzp = 3'b100;
        tick();
        br_if.br_valid = 1'b0;
        chk("pre_rst_done", 16'(br_if.br_done), 16'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_done", 16'(br_if.br_done), 16'd0);
        chk("mid_rst_taken", 16'(br_if.br_taken), 16'd0);
        chk("mid_rst_cc", 16'(cc_nzp), 16'b010);
        chk("mid_rst_cnt", 16'(taken_cnt), 16'd0);
        chk("mid_rst_err", 16'(cc_err), 16'd0);
        chk("mid_rst_ready", 16'(br_if.br_ready), 16'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 16'(br_if.br_ready), 16'd1);
        tick();
        chk("post_rst_no_done", 16'(br_if.br_done), 16'd0);
        chk("post_rst_cnt", 16'(taken_cnt), 16'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
